// File: rtl/music_pkg.sv
// Shared definitions for the music audio post-processor: register map,
// reset values and ramp FSM encoding.
package music_pkg;

  localparam logic [1:0] VOL  = 2'd0;
  localparam logic [1:0] RATE = 2'd1;
  localparam logic [1:0] CTRL = 2'd2;
  localparam logic [1:0] CUR  = 2'd3;

  localparam logic [7:0] VOL_RST  = 8'hFF;
  localparam logic [7:0] RATE_RST = 8'h00;
  localparam logic [7:0] CTRL_RST = 8'h02;

  typedef enum logic [1:0] {
    STEADY    = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/music_dc_blocker.sv
// Leaky-integrator DC estimate of the PSG mix and the centring subtraction;
// the centred sample is registered on each sample strobe.
module music_dc_blocker
  import music_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_in,
  input  logic [9:0]         audio_in,
  input  logic               dc_en,
  output logic signed [10:0] x
);

  localparam int ACC_W = 10 + DC_SHIFT;
  localparam logic [ACC_W-1:0] ACC_RST = ACC_W'(512) << DC_SHIFT;

  logic [ACC_W-1:0]    dc_acc;
  logic [9:0]          dc;
  logic signed [10:0]  x_next;

  assign dc = dc_acc[ACC_W-1:DC_SHIFT];

  // The estimate used for centring is the one before this sample's update.
  always_comb begin
    if (dc_en) x_next = $signed({1'b0, audio_in}) - $signed({1'b0, dc});
    else       x_next = $signed({1'b0, audio_in}) - 11'sd512;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dc_acc <= ACC_RST;
      x      <= '0;
    end else if (sample_in) begin
      dc_acc <= dc_acc + ACC_W'(audio_in) - ACC_W'(dc);
      x      <= x_next;
    end
  end

endmodule

// File: rtl/music_audio_post.sv
// PSG post-processor: CPU register file, timed volume ramp FSM, and the
// DC-removal / gain / output pipeline producing 16-bit signed samples.
module music_audio_post
  import music_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        write,
  output logic [7:0]  data_out,
  input  logic [9:0]  audio_in,
  input  logic        sample_in,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output ramp_state_e ramp_state
);

  logic [7:0]  target, rate, cur, rate_cnt;
  logic        mute, dc_en;
  ramp_state_e state;

  logic [7:0]  cur_n, cnt_n, stepped;
  ramp_state_e state_n;
  logic        up, rate_wr;

  logic signed [10:0] x;
  logic [7:0]         g_q;
  logic               v1, v2;
  logic signed [19:0] prod;
  logic [15:0]        p_q;
  logic               unused_prod;

  music_dc_blocker #(.DC_SHIFT(DC_SHIFT)) u_dc (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_in (sample_in),
    .audio_in  (audio_in),
    .dc_en     (dc_en),
    .x         (x)
  );

  assign ramp_state = state;
  assign up         = target > cur;
  assign stepped    = up ? cur + 8'd1 : cur - 8'd1;
  assign rate_wr    = write && (addr == VOL || addr == RATE);

  always_comb begin
    data_out = '0;
    case (addr)
      VOL:     data_out = target;
      RATE:    data_out = rate;
      CTRL:    data_out = {6'b0, dc_en, mute};
      default: data_out = cur;
    endcase
  end

  // The tick that enters a ramp counts as the first tick of its step period,
  // so it leaves rate_cnt at 1; after a step the counter wraps to 0.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = rate_cnt;
    if (sample_in) begin
      if (rate_wr) begin
        state_n = STEADY;
        cnt_n   = '0;
      end else begin
        case (state)
          STEADY: begin
            if (cur != target) begin
              if (rate == 8'd0) begin
                cur_n = target;
              end else begin
                state_n = up ? RAMP_UP : RAMP_DOWN;
                cnt_n   = 8'd1;
              end
            end
          end
          RAMP_UP, RAMP_DOWN: begin
            if (cur == target) begin
              state_n = STEADY;
              cnt_n   = '0;
            end else if (up != (state == RAMP_UP)) begin
              state_n = up ? RAMP_UP : RAMP_DOWN;
              cnt_n   = 8'd1;
            end else if (rate_cnt >= rate) begin
              cur_n = stepped;
              cnt_n = '0;
              if (stepped == target) state_n = STEADY;
            end else begin
              cnt_n = rate_cnt + 8'd1;
            end
          end
          default: begin
            state_n = STEADY;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target   <= VOL_RST;
      rate     <= RATE_RST;
      mute     <= CTRL_RST[0];
      dc_en    <= CTRL_RST[1];
      cur      <= VOL_RST;
      rate_cnt <= '0;
      state    <= STEADY;
    end else begin
      if (write && addr == VOL)  target <= data_in;
      if (write && addr == RATE) rate   <= data_in;
      if (write && addr == CTRL) {dc_en, mute} <= data_in[1:0];
      cur      <= cur_n;
      rate_cnt <= cnt_n;
      state    <= state_n;
    end
  end

  assign prod        = 20'(x) * 20'($signed({1'b0, g_q}));
  assign unused_prod = ^{prod[19], prod[2:0]};

  // Gain is captured with the sample, before that tick's ramp step lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_q         <= '0;
      v1          <= 1'b0;
      p_q         <= '0;
      v2          <= 1'b0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
    end else begin
      v1          <= sample_in;
      v2          <= v1;
      audio_valid <= v2;
      if (sample_in) g_q <= mute ? 8'd0 : cur;
      if (v1)        p_q <= prod[18:3];
      if (v2)        audio_out <= p_q;
    end
  end

endmodule

// File: tb/tb_music_audio_post.sv
// Directed testbench for music_audio_post: reset values, latency, gain math,
// full-throughput samples, DC decay, volume ramping, mute and mid-pipe reset.
module tb_music_audio_post;
  import music_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic        write;
  logic [7:0]  data_out;
  logic [9:0]  audio_in;
  logic        sample_in;
  logic [15:0] audio_out;
  logic        audio_valid;
  ramp_state_e ramp_state;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  logic [9:0]  vec_in  [4] = '{10'd1023, 10'd0, 10'd700, 10'd300};
  logic [15:0] vec_exp [4] = '{16'h3FA0, 16'hC040, 16'h1768, 16'hE59A};

  always #5 clk = ~clk;

  music_audio_post #(.DC_SHIFT(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .addr        (addr),
    .data_in     (data_in),
    .write       (write),
    .data_out    (data_out),
    .audio_in    (audio_in),
    .sample_in   (sample_in),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .ramp_state  (ramp_state)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0; write = 1'b0; sample_in = 1'b0;
    addr = '0; data_in = '0; audio_in = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; data_in = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    addr = a;
    #1 d = data_out;
  endtask

  // Leaves the bench one step after the edge that raises audio_valid.
  task automatic tick_sample(input logic [9:0] a);
    @(posedge clk); #1;
    audio_in = a; sample_in = 1'b1;
    @(posedge clk); #1;
    sample_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n, input logic [9:0] a);
    for (int i = 0; i < n; i++) tick_sample(a);
  endtask

  task automatic write_with_sample(input logic [1:0] a, input logic [7:0] d, input logic [9:0] s);
    @(posedge clk); #1;
    addr = a; data_in = d; write = 1'b1;
    audio_in = s; sample_in = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; sample_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] rd;
    logic [7:0] want [4] = '{8'hFF, 8'h00, 8'h02, 8'hFF};
    do_reset();
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), rd);
      checks++;
      if (rd !== want[r]) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h want %h", r, rd, want[r]);
      end
    end
    checks++;
    if (audio_out !== 16'h0000) begin
      errors++; $display("FAIL reset_audio_out: got %h want 0000", audio_out);
    end
    checks++;
    if (audio_valid !== 1'b0) begin
      errors++; $display("FAIL reset_audio_valid: got %b want 0", audio_valid);
    end
    checks++;
    if (ramp_state !== STEADY) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", ramp_state, STEADY);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      audio_in = 10'd512; sample_in = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        sample_in = 1'b0;
        checks++;
        if (audio_valid !== (c == 3)) begin
          errors++;
          $display("FAIL latency_valid s%0d c%0d: got %b want %b", k, c, audio_valid, (c == 3));
        end
        if (c == 3) begin
          checks++;
          if (audio_out !== 16'h0000) begin
            errors++; $display("FAIL latency_out s%0d: got %h want 0000", k, audio_out);
          end
        end
      end
    end
  endtask

  task automatic test_full_scale();
    do_reset();
    cpu_write(CTRL, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick_sample(vec_in[i]);
      checks++;
      if (audio_valid !== 1'b1 || audio_out !== vec_exp[i]) begin
        errors++;
        $display("FAIL full_scale[%0d]: got %h valid %b want %h", i, audio_out, audio_valid, vec_exp[i]);
      end
    end
    // Rate 0: the jump lands on the first tick, but that tick still uses 0xFF.
    cpu_write(VOL, 8'h40);
    tick_sample(10'd1023);
    checks++;
    if (audio_out !== 16'h3FA0) begin
      errors++; $display("FAIL gain_before_jump: got %h want 3fa0", audio_out);
    end
    tick_sample(10'd1023);
    checks++;
    if (audio_out !== 16'h0FF8) begin
      errors++; $display("FAIL gain_after_jump: got %h want 0ff8", audio_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    do_reset();
    cpu_write(CTRL, 8'h00);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        audio_in = vec_in[i]; sample_in = 1'b1;
        exp_q.push_back(vec_exp[i]);
      end else begin
        sample_in = 1'b0;
      end
      if (i >= 3 && i < 7) begin
        want = exp_q.pop_front();
        checks++;
        if (audio_valid !== 1'b1 || audio_out !== want) begin
          errors++;
          $display("FAIL b2b_out step%0d: got %h valid %b want %h", i, audio_out, audio_valid, want);
        end
      end else begin
        checks++;
        if (audio_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_idle step%0d: got valid %b want 0", i, audio_valid);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_dc_decay();
    int prev, cur_v, rises;
    do_reset();
    rises = 0;
    prev = 0;
    for (int n = 0; n < 4000; n++) begin
      tick_sample(10'd800);
      cur_v = int'($signed(audio_out));
      if (n == 0) begin
        checks++;
        if (audio_out !== 16'h23DC) begin
          errors++; $display("FAIL dc_first: got %h want 23dc", audio_out);
        end
      end else if (cur_v > prev) begin
        rises++;
      end
      prev = cur_v;
    end
    checks++;
    if (rises != 0) begin
      errors++; $display("FAIL dc_monotonic: got %0d rises want 0", rises);
    end
    checks++;
    if (prev > 32 || prev < -32) begin
      errors++; $display("FAIL dc_final: got %0d want |x|<=32", prev);
    end
  endtask

  task automatic test_ramp();
    logic [7:0] rd;
    do_reset();
    cpu_write(RATE, 8'd3);
    cpu_write(VOL, 8'h00);
    ticks(8, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'hFD || ramp_state !== RAMP_DOWN) begin
      errors++; $display("FAIL ramp_8: got %h st %0d want fd st %0d", rd, ramp_state, RAMP_DOWN);
    end
    ticks(1011, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h01 || ramp_state !== RAMP_DOWN) begin
      errors++; $display("FAIL ramp_1019: got %h st %0d want 01 st %0d", rd, ramp_state, RAMP_DOWN);
    end
    ticks(1, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h00 || ramp_state !== STEADY) begin
      errors++; $display("FAIL ramp_1020: got %h st %0d want 00 st %0d", rd, ramp_state, STEADY);
    end
  endtask

  task automatic test_reversal();
    logic [7:0] rd;
    do_reset();
    cpu_write(RATE, 8'd3);
    cpu_write(VOL, 8'h00);
    ticks(511, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h80) begin
      errors++; $display("FAIL rev_start: got %h want 80", rd);
    end
    // This tick would have stepped to 0x7F; the coincident write suppresses it.
    write_with_sample(VOL, 8'hFF, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h80) begin
      errors++; $display("FAIL rev_suppress: got %h want 80", rd);
    end
    ticks(3, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h80) begin
      errors++; $display("FAIL rev_wait: got %h want 80", rd);
    end
    ticks(1, 10'd512);
    read_reg(CUR, rd);
    checks++;
    if (rd !== 8'h81 || ramp_state !== RAMP_UP) begin
      errors++; $display("FAIL rev_step: got %h st %0d want 81 st %0d", rd, ramp_state, RAMP_UP);
    end
  endtask

  task automatic test_mute();
    logic [7:0] rd;
    logic [7:0] want_cur [4] = '{8'hFF, 8'hFE, 8'hFE, 8'hFD};
    do_reset();
    cpu_write(CTRL, 8'h01);
    cpu_write(RATE, 8'd1);
    cpu_write(VOL, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick_sample(10'd1023);
      read_reg(CUR, rd);
      checks++;
      if (audio_out !== 16'h0000 || rd !== want_cur[i]) begin
        errors++;
        $display("FAIL mute_tick%0d: got out %h cur %h want 0000 cur %h", i, audio_out, rd, want_cur[i]);
      end
    end
    cpu_write(CTRL, 8'h00);
    tick_sample(10'd1023);
    checks++;
    if (audio_out !== 16'h3F20) begin
      errors++; $display("FAIL unmute_gain: got %h want 3f20", audio_out);
    end
    tick_sample(10'd1023);
    read_reg(CUR, rd);
    checks++;
    if (audio_out !== 16'h3F20 || rd !== 8'hFC) begin
      errors++; $display("FAIL unmute_step: got out %h cur %h want 3f20 cur fc", audio_out, rd);
    end
  endtask

  task automatic test_reset_midpipe();
    logic [7:0] rd;
    logic [7:0] want [4] = '{8'hFF, 8'h00, 8'h02, 8'hFF};
    int seen;
    do_reset();
    cpu_write(CTRL, 8'h00);
    cpu_write(RATE, 8'd5);
    cpu_write(VOL, 8'h10);
    @(posedge clk); #1;
    audio_in = 10'd1023; sample_in = 1'b1;
    @(posedge clk); #1;
    sample_in = 1'b0;
    reset_n = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    if (audio_valid) seen++;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (audio_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midpipe_valid: got %0d strobes want 0", seen);
    end
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), rd);
      checks++;
      if (rd !== want[r]) begin
        errors++; $display("FAIL midpipe_reg%0d: got %h want %h", r, rd, want[r]);
      end
    end
    checks++;
    if (audio_out !== 16'h0000 || ramp_state !== STEADY) begin
      errors++; $display("FAIL midpipe_out: got %h st %0d want 0000 st %0d", audio_out, ramp_state, STEADY);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_scale();
    test_back_to_back();
    test_dc_decay();
    test_ramp();
    test_reversal();
    test_mute();
    test_reset_midpipe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
